// File: rtl/pdp8_run_ctrl.sv
// -----------------------------------------------------------------------------
// pdp8_run_ctrl
//
// Run controller for the PDP8 ISA-level model. After reset is released the
// CPU is held idle for START_DELAY+1 cycles. Then a single start pulse is
// issued together with the start PC. While the CPU runs, RUN cycles and
// completed instructions are counted. The run ends on HLT, or on watchdog
// expiry when that feature is compiled in.
//
// Optional feature macro: PDP8_RUN_WATCHDOG_EN
//   defined     : watchdog comparator and TIMEOUT state present
//   not defined : RUN exits only on halt or reset; timeout tied to 0
//
// Parameters
//   START_DELAY    cycles spent in WAIT after reset release (0 is legal)
//   PC_START       constant start address driven on start_pc
//   CNT_WIDTH      width of cycle_count and instr_count
//   WATCHDOG_LIMIT maximum RUN cycles before timeout (1 .. 2^CNT_WIDTH-1)
//
// Ports
//   clk          in   system clock
//   reset_n      in   synchronous active-low reset
//   halt         in   CPU executed HLT (level)
//   instr_done   in   one-cycle pulse per completed instruction
//   start        out  one-cycle start pulse to the CPU
//   start_pc     out  PC_START
//   run          out  high while running
//   done         out  sticky, run ended (halt or timeout)
//   timeout      out  sticky, run ended by the watchdog
//   cycle_count  out  RUN cycles, saturating
//   instr_count  out  instructions completed in RUN, saturating
// -----------------------------------------------------------------------------
module pdp8_run_ctrl #(
    parameter int          START_DELAY    = 16,
    parameter logic [11:0] PC_START       = 12'o0200,
    parameter int          CNT_WIDTH      = 32,
    parameter int          WATCHDOG_LIMIT = 500000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 halt,
    input  logic                 instr_done,
    output logic                 start,
    output logic [11:0]          start_pc,
    output logic                 run,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
);

`ifdef PDP8_RUN_WATCHDOG_EN
    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_START   = 3'd1,
        ST_RUN     = 3'd2,
        ST_HALTED  = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_START   = 2'd1,
        ST_RUN     = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;
`endif

    // delay counter only needs to reach START_DELAY
    localparam int                   DLY_W    = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);
    localparam logic [DLY_W-1:0]     DLY_LAST = DLY_W'(START_DELAY);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        logic [CNT_WIDTH-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_WIDTH'(1);
        end
        return result;
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [DLY_W-1:0]       delay_cnt_r;
    logic [DLY_W-1:0]       delay_cnt_nxt_s;
    logic [CNT_WIDTH-1:0]   cycle_count_r;
    logic [CNT_WIDTH-1:0]   cycle_count_nxt_s;
    logic [CNT_WIDTH-1:0]   instr_count_r;
    logic [CNT_WIDTH-1:0]   instr_count_nxt_s;
    logic                   start_r;
    logic                   run_r;
    logic                   done_r;
    logic                   timeout_r;

`ifdef PDP8_RUN_WATCHDOG_EN
    // The hit is taken in the RUN cycle whose count is LIMIT-1, so the
    // count that is stored at the exit edge equals LIMIT exactly.
    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(WATCHDOG_LIMIT - 1);
    logic wd_hit_s;
    assign wd_hit_s = (cycle_count_r == WD_LAST);
`endif

    // Next-state, delay counter and run counters.
    always_comb begin
        state_nxt_s       = state_r;
        delay_cnt_nxt_s   = delay_cnt_r;
        cycle_count_nxt_s = cycle_count_r;
        instr_count_nxt_s = instr_count_r;
        case (state_r)
            ST_WAIT: begin
                if (delay_cnt_r == DLY_LAST) begin
                    state_nxt_s = ST_START;
                end else begin
                    delay_cnt_nxt_s = delay_cnt_r + DLY_W'(1);
                end
            end
            ST_START: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                cycle_count_nxt_s = sat_inc(cycle_count_r);
                if (instr_done) begin
                    instr_count_nxt_s = sat_inc(instr_count_r);
                end else begin
                    instr_count_nxt_s = instr_count_r;
                end
                // halt has priority over a simultaneous watchdog hit
                if (halt) begin
                    state_nxt_s = ST_HALTED;
`ifdef PDP8_RUN_WATCHDOG_EN
                end else if (wd_hit_s) begin
                    state_nxt_s = ST_TIMEOUT;
`endif
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_nxt_s = ST_HALTED;
            end
            default: begin
                state_nxt_s = state_r;
            end
        endcase
    end

    // State, counters and registered outputs (decoded from the next state).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_WAIT;
            delay_cnt_r   <= '0;
            cycle_count_r <= '0;
            instr_count_r <= '0;
            start_r       <= 1'b0;
            run_r         <= 1'b0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            delay_cnt_r   <= delay_cnt_nxt_s;
            cycle_count_r <= cycle_count_nxt_s;
            instr_count_r <= instr_count_nxt_s;
            start_r       <= (state_nxt_s == ST_START);
            run_r         <= (state_nxt_s == ST_RUN);
`ifdef PDP8_RUN_WATCHDOG_EN
            done_r        <= (state_nxt_s == ST_HALTED) || (state_nxt_s == ST_TIMEOUT);
            timeout_r     <= (state_nxt_s == ST_TIMEOUT);
`else
            done_r        <= (state_nxt_s == ST_HALTED);
            timeout_r     <= 1'b0;
`endif
        end
    end

    assign start       = start_r;
    assign start_pc    = PC_START;
    assign run         = run_r;
    assign done        = done_r;
    assign timeout     = timeout_r;
    assign cycle_count = cycle_count_r;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_pdp8_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pdp8_run_ctrl
//
// Two instances share the same inputs: a wide-counter instance with the
// default settling delay, and a narrow 4-bit-counter instance that starts
// immediately so that saturation is exercised. A reference model tracks
// edges since reset release and derives every output from it.
// -----------------------------------------------------------------------------
module tb_pdp8_run_ctrl;

    localparam int D0 = 16;
    localparam int W0 = 32;
    localparam int L0 = 50;
    localparam int D1 = 0;
    localparam int W1 = 4;
    localparam int L1 = 12;
`ifdef PDP8_RUN_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic halt = 1'b0;
    logic instr_done = 1'b0;

    logic          start0, run0, done0, to0;
    logic [11:0]   pc0;
    logic [W0-1:0] cyc0, ins0;
    logic          start1, run1, done1, to1;
    logic [11:0]   pc1;
    logic [W1-1:0] cyc1, ins1;

    always #5 clk = ~clk;

    pdp8_run_ctrl #(.START_DELAY(D0), .PC_START(12'o0200), .CNT_WIDTH(W0), .WATCHDOG_LIMIT(L0)) dut0 (
        .clk(clk), .reset_n(reset_n), .halt(halt), .instr_done(instr_done),
        .start(start0), .start_pc(pc0), .run(run0), .done(done0), .timeout(to0),
        .cycle_count(cyc0), .instr_count(ins0)
    );

    pdp8_run_ctrl #(.START_DELAY(D1), .PC_START(12'o0200), .CNT_WIDTH(W1), .WATCHDOG_LIMIT(L1)) dut1 (
        .clk(clk), .reset_n(reset_n), .halt(halt), .instr_done(instr_done),
        .start(start1), .start_pc(pc1), .run(run1), .done(done1), .timeout(to1),
        .cycle_count(cyc1), .instr_count(ins1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int     mk[2];          // edges since reset release
    bit     ms[2], mr[2], md[2], mt[2];
    longint mc[2], mi[2];
    bit     mvalid = 1'b0;

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v == mx) ? v : v + 1;
    endfunction

    task automatic model_step(input int i, input int d, input int l, input int w);
        longint old_c;
        if (!reset_n) begin
            mk[i] = 0; ms[i] = 0; mr[i] = 0; md[i] = 0; mt[i] = 0;
            mc[i] = 0; mi[i] = 0;
        end else begin
            mk[i] = mk[i] + 1;
            if (mr[i]) begin
                old_c = mc[i];
                mc[i] = sat(mc[i], w);
                if (instr_done) mi[i] = sat(mi[i], w);
                if (halt) begin
                    mr[i] = 0; md[i] = 1;
                end else if (WD && old_c == longint'(l - 1)) begin
                    mr[i] = 0; md[i] = 1; mt[i] = 1;
                end
            end else if (ms[i]) begin
                mr[i] = 1;
            end
            // the start pulse follows edge number d+1 after release
            ms[i] = (mk[i] == d + 1);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0, D0, L0, W0);
        model_step(1, D1, L1, W1);
        if (!reset_n) mvalid = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        check("start_pc0", pc0, 12'o0200);
        check("start_pc1", pc1, 12'o0200);
        if (mvalid) begin
            check("start0", start0, ms[0]);
            check("run0", run0, mr[0]);
            check("done0", done0, md[0]);
            check("timeout0", to0, mt[0]);
            check("cycle_count0", cyc0, mc[0]);
            check("instr_count0", ins0, mi[0]);
            check("start1", start1, ms[1]);
            check("run1", run1, mr[1]);
            check("done1", done1, md[1]);
            check("timeout1", to1, mt[1]);
            check("cycle_count1", cyc1, mc[1]);
            check("instr_count1", ins1, mi[1]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_start"}, start0, 1'b0);
        check({tag, "_run"}, run0, 1'b0);
        check({tag, "_done"}, done0, 1'b0);
        check({tag, "_timeout"}, to0, 1'b0);
        check({tag, "_cyc"}, cyc0, 0);
        check({tag, "_ins"}, ins0, 0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        tick(3);
        check_zero0("lit_reset");
        check("lit_reset_pc", pc0, 12'o0200);

        // startup and watchdog stimulus: instr_done every cycle, no halt
        reset_n = 1'b1; instr_done = 1'b1; halt = 1'b0;
        tick(17);
        check("lit_start_e17", start0, 1'b1);
        check("lit_run_e17", run0, 1'b0);
        tick(1);
        check("lit_run_e18", run0, 1'b1);
        check("lit_start_e18", start0, 1'b0);
        tick(50);
        check("lit_cyc_50", cyc0, 50);
        check("lit_ins_50", ins0, 50);
        check("lit_to_50", to0, WD);
        check("lit_run_50", run0, !WD);
        tick(150);
        check("lit_cyc_200", cyc0, WD ? 50 : 200);
        check("lit_to_200", to0, WD);
        check("lit_done_200", done0, WD);
        check("lit_sat_cyc", cyc1, WD ? 12 : 15);
        check("lit_sat_ins", ins1, WD ? 12 : 15);

        // halt together with the 10th instruction
        reset_n = 1'b0; instr_done = 1'b0; tick(1);
        check_zero0("lit_rst2");
        reset_n = 1'b1;
        tick(18);
        check("lit_run_ep2", run0, 1'b1);
        for (int p = 1; p <= 10; p++) begin
            instr_done = 1'b1; halt = (p == 10);
            tick(1);
            instr_done = 1'b0; halt = 1'b0;
            tick(1);
        end
        tick(100);
        check("lit_halt_ins", ins0, 10);
        check("lit_halt_cyc", cyc0, 19);
        check("lit_halt_done", done0, 1'b1);
        check("lit_halt_to", to0, 1'b0);
        check("lit_halt_run", run0, 1'b0);

        // halt in the 50th RUN cycle beats the watchdog
        reset_n = 1'b0; tick(1);
        reset_n = 1'b1;
        tick(18 + 49);
        check("lit_cyc_49", cyc0, 49);
        check("lit_to_49", to0, 1'b0);
        halt = 1'b1; tick(1);
        halt = 1'b0; tick(5);
        check("lit_hw_done", done0, 1'b1);
        check("lit_hw_to", to0, 1'b0);
        check("lit_hw_cyc", cyc0, 50);

        // reset in the middle of a run
        reset_n = 1'b0; tick(1);
        reset_n = 1'b1;
        tick(18 + 37);
        check("lit_cyc_37", cyc0, 37);
        reset_n = 1'b0; tick(1);
        check_zero0("lit_midrst");
        reset_n = 1'b1;
        tick(16);
        check("lit_restart_e16", start0, 1'b0);
        tick(1);
        check("lit_restart_e17", start0, 1'b1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset_n    = ($urandom_range(0, 299) != 0);
            halt       = ($urandom_range(0, 99) == 0);
            instr_done = $urandom_range(0, 1) == 1;
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pdp8_run_ctrl.md
# pdp8_run_ctrl

Simulation run controller for the PDP8 ISA-level model, directly downstream of the clock/reset generator. It consumes `clk` and `reset_n` and holds the CPU idle for a programmable settling period after reset release. It then issues a single start pulse with the start PC, tracks cycles and completed instructions while the CPU runs, and reports completion on HLT or on watchdog expiry.

## Interface
Parameters:
- `START_DELAY`, 16: number of cycles in the WAIT state after reset release before `start` fires; 0 is legal.
- `PC_START`, 12'o0200: start address presented on `start_pc`.
- `CNT_WIDTH`, 32: width of both counters.
- `WATCHDOG_LIMIT`, 500000: maximum number of RUN cycles before timeout; must be ≥1 and < 2^CNT_WIDTH.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous active-low reset, sampled on the `clk` rising edge.
- `halt`  in  1  level from CPU: HLT executed.
- `instr_done`  in  1  one-cycle pulse per completed instruction.
- `start`  out  1  one-cycle start pulse to the CPU.
- `start_pc`  out  12  constant `PC_START`.
- `run`  out  1  high while in RUN.
- `done`  out  1  sticky: run ended (halt or timeout).
- `timeout`  out  1  sticky: run ended by watchdog.
- `cycle_count`  out  CNT_WIDTH  cycles spent in RUN.
- `instr_count`  out  CNT_WIDTH  instructions completed in RUN.

## Operation
- FSM states: WAIT → START → RUN → {HALTED | TIMEOUT}. HALTED and TIMEOUT are terminal until reset.
- Reset, on any edge with `reset_n`=0:
  - State goes to WAIT and `delay_cnt` to 0.
  - `start`, `run`, `done`, `timeout` go to 0; `cycle_count` and `instr_count` go to 0.
  - This applies mid-run as well; the full sequence restarts after release.
- WAIT: on each edge, if `delay_cnt`==`START_DELAY` go to START; otherwise increment `delay_cnt`.
- START: `start`=1 for exactly one cycle, then RUN unconditionally. `halt` and `instr_done` are ignored in this state.
- RUN: `run`=1.
  - `cycle_count` increments every RUN cycle.
  - `instr_count` increments on each cycle where `instr_done`=1.
  - Both counters saturate at all-ones and never wrap.
  - `halt`=1 → HALTED at the next edge.
  - A watchdog hit (RUN cycle in which `cycle_count`==`WATCHDOG_LIMIT`-1 and `halt`=0) → TIMEOUT at the next edge.
- HALTED: `done`=1, `timeout`=0, `run`=0. Counters freeze.
- TIMEOUT: `done`=1, `timeout`=1, `run`=0. Counters freeze.
- Simultaneous events:
  - `halt` and `instr_done` in the same RUN cycle: the instruction is counted, then the state moves to HALTED.
  - `halt` and a watchdog hit in the same cycle: halt wins and `timeout` stays 0.
- `halt` and `instr_done` are ignored in WAIT, START, HALTED and TIMEOUT.
- `start_pc` is the constant `PC_START` at all times, including during reset.

## Timing
- All outputs are registered; none have a combinational path from inputs.
- Let E1 be the first rising edge with `reset_n`=1.
  - `start` is high during the cycle after edge E(`START_DELAY`+1).
  - `run` rises one edge later.
- Latencies:
  - `halt` sampled high at edge En: `run`=0 and `done`=1 after En.
  - `cycle_count` after edge En reflects RUN cycles completed through En.
  - `instr_done` sampled at En is visible on `instr_count` after En.
- Watchdog: a run with no halt spends exactly `WATCHDOG_LIMIT` cycles in RUN. Final `cycle_count`=`WATCHDOG_LIMIT`.
- Reset takes effect at the first edge where `reset_n`=0; there is no asynchronous path.

## Configuration
- `PDP8_RUN_WATCHDOG_EN` defined:
  - The watchdog comparator and the TIMEOUT state are compiled in, as described above.
- `PDP8_RUN_WATCHDOG_EN` not defined:
  - No TIMEOUT state and no comparator; `WATCHDOG_LIMIT` is unused.
  - `timeout` is tied to 0.
  - RUN exits only on `halt` or reset; counters still saturate.

## Test plan
- Startup: `START_DELAY`=16, release reset at E1, hold `halt`=0 → `start`=1 only after E17, `run`=1 from after E18, `start_pc`=12'o0200 throughout.
- Halt with count: 10 `instr_done` pulses, then `halt` asserted in the same cycle as the 10th pulse → `instr_count`=10, `done`=1, `timeout`=0, `run`=0, counters frozen for 100 further cycles.
- Watchdog (macro defined): `WATCHDOG_LIMIT`=50, `halt` never asserted → `timeout`=1, `done`=1, `cycle_count`=50. Repeat with `halt` raised in the 50th RUN cycle → `timeout`=0, `done`=1.
- Watchdog compiled out: same stimulus for 200 cycles → `timeout`=0, `run`=1, `cycle_count`=200.
- Reset mid-run: assert `reset_n`=0 for one edge during RUN with `cycle_count`=37 → all outputs 0 after that edge. After release, `start` fires again after `START_DELAY`+1 edges.
- Saturation: `CNT_WIDTH`=4, macro undefined, 20 RUN cycles each with `instr_done`=1 → both counters hold at 15.
